// File: rtl/bird_pkg.sv
// Shared widths and arbiter state encoding for the bird memory subsystem.
package bird_pkg;
   localparam int BIRD_AW = 12;
   localparam int BIRD_DW = 16;

   typedef enum logic {S_CPU, S_DMA} arb_state_t;
endpackage

// File: rtl/bird_mem_arbiter.sv
// CPU/DMA arbiter for the single-port async-read RAM; registered owner, combinational mux.
// Latency: idle-CPU DMA request granted next cycle. Backpressure: cpu_stall holds the CPU, dma_req waits for dma_gnt.
// Optional BIRD_ARB_FAIR_EN bounds DMA starvation via a wait counter.
module bird_mem_arbiter
   import bird_pkg::*;
#(
   parameter int AW        = BIRD_AW,
   parameter int DW        = BIRD_DW,
   parameter int BURST_LEN = 4,
   parameter int MAX_WAIT  = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_stall,
   input  logic          dma_req,
   input  logic          dma_we,
   input  logic [AW-1:0] dma_addr,
   input  logic [DW-1:0] dma_wdata,
   output logic [DW-1:0] dma_rdata,
   output logic          dma_gnt,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_we,
   input  logic [DW-1:0] mem_rdata
);
   localparam int CNT_MAX = (BURST_LEN > MAX_WAIT) ? BURST_LEN : MAX_WAIT;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] BURST_LAST = CW'(BURST_LEN - 1);

   arb_state_t    state, state_nxt;
   logic [CW-1:0] burst_cnt, burst_cnt_nxt;
   logic          starve;

`ifdef BIRD_ARB_FAIR_EN
   localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);
   logic [CW-1:0] wait_cnt, wait_cnt_nxt;
   assign starve = (wait_cnt == WAIT_LAST);
`else
   assign starve = 1'b0;
`endif

   assign cpu_rdata = mem_rdata;
   assign dma_rdata = mem_rdata;

   // Owner mux; reset forces the bus quiet regardless of requests.
   always_comb begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = cpu_we & cpu_req;
      dma_gnt   = 1'b0;
      cpu_stall = 1'b0;
      if (state == S_DMA) begin
         mem_addr  = dma_addr;
         mem_wdata = dma_wdata;
         mem_we    = dma_we & dma_req;
         dma_gnt   = dma_req;
         cpu_stall = cpu_req;
      end
      if (rst) begin
         mem_we    = 1'b0;
         dma_gnt   = 1'b0;
         cpu_stall = 1'b0;
      end
   end

   always_comb begin
      state_nxt     = state;
      burst_cnt_nxt = burst_cnt;
`ifdef BIRD_ARB_FAIR_EN
      wait_cnt_nxt  = wait_cnt;
`endif
      case (state)
         S_CPU: begin
            if (dma_req && (!cpu_req || starve)) begin
               state_nxt     = S_DMA;
               burst_cnt_nxt = '0;
`ifdef BIRD_ARB_FAIR_EN
               wait_cnt_nxt  = '0;
            end else if (!dma_req) begin
               wait_cnt_nxt = '0;
            end else if (cpu_req && wait_cnt != WAIT_LAST) begin
               wait_cnt_nxt = wait_cnt + CW'(1);
`endif
            end
         end
         S_DMA: begin
            // Burst length is only enforced while the CPU is waiting.
            if (!dma_req || (cpu_req && burst_cnt == BURST_LAST)) begin
               state_nxt     = S_CPU;
               burst_cnt_nxt = '0;
            end else if (burst_cnt != BURST_LAST) begin
               burst_cnt_nxt = burst_cnt + CW'(1);
            end
         end
         default: state_nxt = S_CPU;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_CPU;
         burst_cnt <= '0;
`ifdef BIRD_ARB_FAIR_EN
         wait_cnt  <= '0;
`endif
      end else begin
         state     <= state_nxt;
         burst_cnt <= burst_cnt_nxt;
`ifdef BIRD_ARB_FAIR_EN
         wait_cnt  <= wait_cnt_nxt;
`endif
      end
   end
endmodule
